// File: rtl/reg_parametrizado_32b_pkg.sv
// Shared constants for the register-file storage elements.
//
// XLEN is the architectural integer width; register instances pass it as
// WIDTH so that every register in the integer and floating-point files
// agrees on the datapath width from a single place.
package reg_parametrizado_32b_pkg;

  localparam int XLEN = 32;

endpackage

// File: rtl/reg_parametrizado_32b_dff_en_ar.sv
// One-bit storage flop with load enable and asynchronous active-high reset.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; forces q to RESET_BIT immediately
//   load  - write enable, sampled on the rising edge of clk
//   d     - data bit captured when load is high
//   q     - stored bit, driven straight from the flop
//
// RESET_BIT lets each bit of a wider register come out of reset with its own
// value, so a multi-bit reset constant is simply spread across the instances.
module dff_en_ar #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic d,
  output logic q
);

  // Reset wins over load; with load low the flop simply keeps its value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_BIT;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_parametrizado_32b.sv
// Parameterizable-width, load-enabled storage register with asynchronous
// active-high reset. One instance per architectural register; the hard-wired
// zero register is an instance with load tied high and in_data tied to zero.
//
// Parameters:
//   WIDTH       - data width in bits (1 or more), defaults to XLEN
//   RESET_VALUE - value forced onto out_data while reset is high
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous, active-high reset
//   load     - write enable, sampled on the rising edge of clk
//   in_data  - data to store
//   out_data - stored value, driven directly from flops
module reg_parametrizado_32b
  import reg_parametrizado_32b_pkg::*;
#(
  parameter int               WIDTH       = XLEN,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  // Every bit shares clk, reset and load so the whole word updates together;
  // there is no path for partial writes. Each bit takes its own reset value
  // from the matching position of RESET_VALUE.
  for (genvar bitIdx = 0; bitIdx < WIDTH; bitIdx++) begin : gBit
    dff_en_ar #(
      .RESET_BIT(RESET_VALUE[bitIdx])
    ) uFlop (
      .clk  (clk),
      .reset(reset),
      .load (load),
      .d    (in_data[bitIdx]),
      .q    (out_data[bitIdx])
    );
  end

endmodule

// File: tb/tb_reg_parametrizado_32b.sv
// Self-checking bench for reg_parametrizado_32b.
//
// Three instances run side by side off one clock and one reset:
//   uMain - default 32-bit register driven by the directed and random stimulus
//   uZero - zero-register usage: load tied high, in_data tied to zero,
//           RESET_VALUE = 0x80000000 so the reset value is visible
//   uW8   - WIDTH = 8 register with its own load and data
// A behavioural model keeps the value each register should be holding.
module tb_reg_parametrizado_32b;

  logic        clk;
  logic        reset;
  logic        load;
  logic [31:0] inData;
  logic [31:0] outData;
  logic [31:0] zeroOut;
  logic        load8;
  logic [7:0]  inData8;
  logic [7:0]  outData8;

  logic [31:0] model;
  logic [31:0] zeroModel;
  logic [7:0]  model8;

  int vectors;
  int miscompares;

  localparam logic [31:0] ZeroResetValue = 32'h8000_0000;

  reg_parametrizado_32b uMain (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .in_data (inData),
    .out_data(outData)
  );

  reg_parametrizado_32b #(
    .RESET_VALUE(ZeroResetValue)
  ) uZero (
    .clk     (clk),
    .reset   (reset),
    .load    (1'b1),
    .in_data (32'h0),
    .out_data(zeroOut)
  );

  reg_parametrizado_32b #(
    .WIDTH(8)
  ) uW8 (
    .clk     (clk),
    .reset   (reset),
    .load    (load8),
    .in_data (inData8),
    .out_data(outData8)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "/main"}, outData, model);
    checkOutput({tag, "/zero"}, zeroOut, zeroModel);
    checkOutput({tag, "/w8"}, {24'h0, outData8}, {24'h0, model8});
  endtask

  // Present inputs, let one rising edge pass, update the model with what that
  // edge should have done, then check all three registers shortly after it.
  task automatic applyStimulus(input string tag, input logic ld,
                               input logic [31:0] d, input logic ld8,
                               input logic [7:0] d8);
    load    = ld;
    inData  = d;
    load8   = ld8;
    inData8 = d8;
    @(posedge clk);
    if (reset) begin
      model     = 32'h0;
      zeroModel = ZeroResetValue;
      model8    = 8'h0;
    end else begin
      if (ld) model = d;
      if (ld8) model8 = d8;
      zeroModel = 32'h0;
    end
    #2;
    checkAll(tag);
  endtask

  // Assert reset between edges: outputs must change without waiting for clk.
  // Reset is released again well before the next edge.
  task automatic pulseReset(input string tag);
    reset = 1'b1;
    #1;
    model     = 32'h0;
    zeroModel = ZeroResetValue;
    model8    = 8'h0;
    checkAll({tag, "/async"});
    #1;
    reset = 1'b0;
    #1;
    checkAll({tag, "/released"});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    load        = 1'b0;
    inData      = 32'h0;
    load8       = 1'b0;
    inData8     = 8'h0;
    model       = 32'h0;
    zeroModel   = ZeroResetValue;
    model8      = 8'h0;

    // Power-up reset, visible before any clock edge.
    #1;
    checkAll("por");
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Load a value, then hit it with an asynchronous reset mid-cycle while
    // load is still high with fresh data pending.
    applyStimulus("preload", 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00);
    load   = 1'b1;
    inData = 32'hDEAD_BEEF;
    #1;
    reset = 1'b1;
    #1;
    model     = 32'h0;
    zeroModel = ZeroResetValue;
    model8    = 8'h0;
    checkAll("rstAsync");

    // Reset held across edges with load high: reset has priority.
    for (int i = 0; i < 3; i++) begin
      applyStimulus("rstPrio", 1'b1, 32'hAAAA_AAAA, 1'b1, 8'h55);
    end
    reset = 1'b0;

    // Load then hold against changing data.
    applyStimulus("load", 1'b1, 32'h1234_5678, 1'b1, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("hold", 1'b0, 32'hFFFF_FFFF, 1'b0, 8'hFF);
    end

    // Back-to-back writes, one per cycle.
    applyStimulus("b2b1", 1'b1, 32'h1, 1'b0, 8'h3C);
    applyStimulus("b2b2", 1'b1, 32'h2, 1'b0, 8'hC3);
    applyStimulus("b2b3", 1'b1, 32'h3, 1'b0, 8'h00);

    // Randomised traffic with occasional resets, both mid-cycle pulses and
    // resets held across an edge.
    for (int i = 0; i < 300; i++) begin
      int unsigned pick;
      pick = $urandom_range(0, 15);
      if (pick == 0) begin
        pulseReset("rand");
      end
      if (pick == 1) begin
        reset = 1'b1;
        applyStimulus("randRst", $urandom_range(0, 1) == 1, $urandom,
                      $urandom_range(0, 1) == 1, 8'($urandom));
        reset = 1'b0;
      end else begin
        applyStimulus("rand", $urandom_range(0, 1) == 1, $urandom,
                      $urandom_range(0, 1) == 1, 8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
